seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
- Serial pattern transmitter. Loads a W-bit pattern and shifts it out MSB first, one bit per clock.
- Repeats the frame a programmable number of times, with an optional idle gap between frames.
- Feeds the team's serial sequence detectors, both as bench stimulus and in loopback self-test paths.
- Default configuration emits the frame 1011.

Parameters:
W, 4, pattern width in bits (W >= 2).
CNT_W, 4, width of the repeat-count input.
GAP_CYC, 0, idle cycles inserted between consecutive frames (0 = back-to-back frames).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request to begin a transmission; sampled only in IDLE.
pattern  input  W  frame bits; bit W-1 is transmitted first.
repeat_n  input  CNT_W  extra frames after the first; total frames = repeat_n+1.
abort  input  1  synchronous cancel of a transmission in progress.
data  output  1  serial bit; 0 whenever data_valid=0.
data_valid  output  1  data carries a pattern bit this cycle.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse after the final bit of the final frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset value of every output is 0; state resets to IDLE.
- All outputs are registered, with no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at an edge latches pattern into a shift register and repeat_n into a repeat counter.
  - The same edge loads bit index W-1 and sets state to SHIFT.
  - data=pattern[W-1] and data_valid=1 are visible after that edge (1-cycle latency from start).
- SHIFT:
  - Each edge advances one bit, so a frame occupies exactly W consecutive valid cycles.
  - After bit 0 with repeat counter > 0: counter decrements and the latched pattern reloads.
  - With GAP_CYC=0 the next frame's MSB follows bit 0 in the immediately next cycle, with no bubble.
  - With GAP_CYC>0 the state goes to GAP.
  - After bit 0 with repeat counter = 0: state goes to DONE.
- GAP:
  - data=0 and data_valid=0 for exactly GAP_CYC cycles.
  - Then SHIFT resumes with the MSB of the next frame.
- DONE:
  - Lasts one cycle with done=1, data_valid=0 and busy=1.
  - Next state is IDLE, where busy=0.
- start is ignored in SHIFT, GAP and DONE; the latched pattern and count are unaffected.
- pattern and repeat_n may change freely after the start edge without affecting the transmission.
- abort=1 in SHIFT, GAP or DONE:
  - Next edge returns to IDLE with data_valid=0, data=0 and busy=0.
  - No done pulse is produced, and the remainder of the frame is discarded.
  - abort has priority over all other transitions.
- abort in IDLE has no effect.
- abort and start both high in IDLE: start wins and the transmission begins.
- repeat_n at its maximum (2^CNT_W - 1) yields 2^CNT_W frames; the counter never wraps.
- rst asserted mid-transmission:
  - All outputs drop to 0 immediately, without waiting for a clock edge.
  - Latched pattern and counters clear.
  - After rst deasserts, the block sits in IDLE until a new start.
- Total valid cycles per transmission = (repeat_n+1)*W.
- Start edge to done pulse = (repeat_n+1)*W + repeat_n*GAP_CYC + 1 cycles.

Test Plan:
- Defaults, pattern=1011, repeat_n=0, start pulsed one cycle -> data 1,0,1,1 on 4 consecutive valid cycles starting 1 cycle after start; done pulses in the 5th cycle; busy high for 5 cycles.
- pattern=1011, repeat_n=2, GAP_CYC=0 -> 12 contiguous valid bits 101110111011 with no bubble; exactly one done pulse, 13 cycles after start.
- GAP_CYC=2 instance, pattern=1011, repeat_n=1 -> 1011, 2 cycles with data_valid=0 and data=0, then 1011; done 11 cycles after start.
- start held high, and pattern changed to 0110 during transmission of 1011 -> the frame stays 1011; no restart until IDLE. If start is still high in IDLE, a new 0110 frame begins on the next edge.
- abort asserted during the 3rd bit of frame 1 of a repeat_n=3 run -> data_valid=0 and busy=0 after the next edge; no done pulse; a subsequent start works normally.
- rst asserted asynchronously mid-frame (between clock edges) -> data, data_valid, busy and done read 0 before the next edge; after release the outputs stay 0 until the next start.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched W-bit frame out MSB first,
// repeating it repeat_n+1 times with an optional idle gap between frames.
module seq_pattern_gen #(
  parameter int W       = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [W-1:0]     pat_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic             data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // Transmit FSM; every output is a register so nothing leaks combinationally from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= {W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      rep_q   <= {CNT_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        data_q  <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              pat_q   <= pattern;
              rep_q   <= repeat_n;
              idx_q   <= IDX_MSB;
              state_q <= SHIFT;
              data_q  <= pattern[W-1];
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              busy_q <= 1'b0;
            end
          end
          SHIFT: begin
            if (idx_q != {IDX_W{1'b0}}) begin
              idx_q  <= idx_q - IDX_ONE;
              data_q <= pat_q[idx_q - IDX_ONE];
            end else if (rep_q != {CNT_W{1'b0}}) begin
              rep_q <= rep_q - CNT_W'(1);
              // Back-to-back frames reload the MSB on the same edge: no bubble.
              if (GAP_CYC == 0) begin
                idx_q  <= IDX_MSB;
                data_q <= pat_q[W-1];
              end else begin
                state_q <= GAP;
                gap_q   <= GAP_LAST;
                data_q  <= 1'b0;
                valid_q <= 1'b0;
              end
            end else begin
              state_q <= DONE;
              data_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          GAP: begin
            if (gap_q == {GAP_W{1'b0}}) begin
              state_q <= SHIFT;
              idx_q   <= IDX_MSB;
              data_q  <= pat_q[W-1];
              valid_q <= 1'b1;
            end else begin
              gap_q <= gap_q - GAP_ONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
